// File: rtl/bcd_display_scan.sv
// bcd_display_scan: bit-serial double-dabble converter feeding a
// multiplexed common-anode 7-segment scanner with blanking gaps.
module bcd_display_scan #(
  parameter int DIGITS    = 4,
  parameter int BIN_W     = 13,
  parameter int SCAN_DIV  = 100000,
  parameter int BLANK_CYC = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [BIN_W-1:0]  number,
  input  logic              load,
  input  logic [DIGITS-1:0] dp,
  input  logic              lz_blank,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [DIGITS-1:0] anode,
  output logic [6:0]        seg,
  output logic              dp_n
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int SR_W  = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIV_W-1:0] GAP_END  = DIV_W'(BLANK_CYC);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

  localparam logic [63:0] LIMIT = pow10(DIGITS);

  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            state_q, state_d;
  logic [SR_W-1:0]   sr_q, sr_d, sr_adj;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovfp_q, ovfp_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;
  logic [BCD_W-1:0]  disp_q, disp_d;

  logic [DIV_W-1:0]  div_q, div_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DIGITS-1:0] anode_q, anode_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_n_q, dp_n_d;

  logic [3:0]        nib;
  logic              upper_nz;
  logic              lz_hide;
  logic              gap;

  // Converter next state: add-3 correction then shift, one bit per cycle.
  always_comb begin
    sr_adj = sr_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (sr_q[BIN_W+4*i +: 4] >= 4'd5)
        sr_adj[BIN_W+4*i +: 4] = sr_q[BIN_W+4*i +: 4] + 4'd3;
    end
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    ovfp_d  = ovfp_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q;
    disp_d  = disp_q;
    unique case (state_q)
      IDLE: begin
        if (load) begin
          sr_d    = {{BCD_W{1'b0}}, number};
          cnt_d   = '0;
          ovfp_d  = 64'(number) >= LIMIT;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sr_d  = {sr_adj[SR_W-2:0], 1'b0};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          done_d  = 1'b1;
          disp_d  = sr_d[SR_W-1 -: BCD_W];
          ovf_d   = ovfp_q;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == SHIFT);
  end

  // Converter and display register state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      ovfp_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      disp_q  <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      ovfp_q  <= ovfp_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      disp_q  <= disp_d;
    end
  end

  // Slot divider and digit index.
  always_comb begin
    div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    idx_d = idx_q;
    if (div_q == DIV_LAST)
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
  end

  // Pin values for the upcoming slot position, so registered pins track the divider.
  always_comb begin
    nib      = 4'd0;
    upper_nz = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (IDX_W'(i) == idx_d)
        nib = disp_d[4*i +: 4];
      if (IDX_W'(i) >= idx_d && disp_d[4*i +: 4] != 4'd0)
        upper_nz = 1'b1;
    end
    lz_hide = lz_blank && (idx_d != '0) && !upper_nz;
    gap     = div_d < GAP_END;
    anode_d = '1;
    seg_d   = 7'b1111111;
    dp_n_d  = 1'b1;
    if (!gap) begin
      anode_d = ~(DIGITS'(1) << idx_d);
      dp_n_d  = ~dp[idx_d];
      if (ovf_d)
        seg_d = 7'b1111110;
      else if (lz_hide)
        seg_d = 7'b1111111;
      else
        seg_d = seg7(nib);
    end
  end

  // Scan state and registered display pins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q   <= '0;
      idx_q   <= '0;
      anode_q <= '1;
      seg_q   <= 7'b1111111;
      dp_n_q  <= 1'b1;
    end else begin
      div_q   <= div_d;
      idx_q   <= idx_d;
      anode_q <= anode_d;
      seg_q   <= seg_d;
      dp_n_q  <= dp_n_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign overflow = ovf_q;
  assign anode    = anode_q;
  assign seg      = seg_q;
  assign dp_n     = dp_n_q;

endmodule

// File: tb/tb_bcd_display_scan.sv
// tb_bcd_display_scan: directed checks of conversion, blanking,
// overflow, load-while-busy, reset abort and scan timing.
module tb_bcd_display_scan;

  logic        clk;
  logic        reset_n;
  logic [12:0] number;
  logic        load4, load3;
  logic [3:0]  dp4;
  logic [2:0]  dp3;
  logic        lz;

  logic        busy4, done4, ovf4, dp_n4;
  logic [3:0]  anode4;
  logic [6:0]  seg4;
  logic        busy3, done3, ovf3, dp_n3;
  logic [2:0]  anode3;
  logic [6:0]  seg3;

  int n_tests;
  int n_fail;

  logic [6:0] seen [4];
  logic [3:0] an;
  logic [6:0] sg;
  int nb, nd;

  localparam logic [6:0] S0 = 7'b0000001;
  localparam logic [6:0] S1 = 7'b1001111;
  localparam logic [6:0] S2 = 7'b0010010;
  localparam logic [6:0] S3 = 7'b0000110;
  localparam logic [6:0] S4 = 7'b1001100;
  localparam logic [6:0] S7 = 7'b0001111;
  localparam logic [6:0] S9 = 7'b0000100;
  localparam logic [6:0] SB = 7'b1111111;
  localparam logic [6:0] SD = 7'b1111110;

  bcd_display_scan #(
    .DIGITS(4), .BIN_W(13), .SCAN_DIV(10), .BLANK_CYC(2)
  ) u4 (
    .clk(clk), .reset_n(reset_n), .number(number), .load(load4),
    .dp(dp4), .lz_blank(lz), .busy(busy4), .done(done4),
    .overflow(ovf4), .anode(anode4), .seg(seg4), .dp_n(dp_n4)
  );

  bcd_display_scan #(
    .DIGITS(3), .BIN_W(13), .SCAN_DIV(10), .BLANK_CYC(2)
  ) u3 (
    .clk(clk), .reset_n(reset_n), .number(number), .load(load3),
    .dp(dp3), .lz_blank(lz), .busy(busy3), .done(done3),
    .overflow(ovf3), .anode(anode3), .seg(seg3), .dp_n(dp_n3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", tag, act, exp);
    end
  endtask

  // Load val into one instance, optionally re-pulse load at sample poke.
  task automatic run(input bit w, input logic [12:0] val, input int poke,
                     output int busy_n, output int done_n);
    busy_n = 0;
    done_n = 0;
    @(negedge clk);
    number = val;
    if (w) load3 = 1'b1;
    else load4 = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (w ? busy3 : busy4) busy_n++;
      if (w ? done3 : done4) done_n++;
      load3 = 1'b0;
      load4 = 1'b0;
      if (c == poke) begin
        number = 13'd99;
        if (w) load3 = 1'b1;
        else load4 = 1'b1;
      end
    end
    load3 = 1'b0;
    load4 = 1'b0;
  endtask

  // Record the segment pattern shown on each lit anode over a frame.
  task automatic grab(input bit w);
    for (int d = 0; d < 4; d++) seen[d] = 7'h00;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      an = w ? {1'b1, anode3} : anode4;
      sg = w ? seg3 : seg4;
      for (int d = 0; d < 4; d++) if (!an[d]) seen[d] = sg;
    end
  endtask

  initial begin
    int lit, gapc, dpl;
    bit found;
    logic [3:0] exp_an;
    logic [3:0] prev;
    n_tests = 0;
    n_fail  = 0;
    reset_n = 1'b0;
    number  = '0;
    load4   = 1'b0;
    load3   = 1'b0;
    dp4     = '0;
    dp3     = '0;
    lz      = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy4, 0);
    check("rst_done", done4, 0);
    check("rst_ovf", ovf4, 0);
    check("rst_anode", anode4, 4'hF);
    check("rst_seg", seg4, SB);
    check("rst_dpn", dp_n4, 1);
    reset_n = 1'b1;

    // basic 1234
    run(0, 13'd1234, -1, nb, nd);
    check("t1_busy_cycles", nb, 13);
    check("t1_done_pulses", nd, 1);
    check("t1_ovf", ovf4, 0);
    grab(0);
    check("t1_d0", seen[0], S4);
    check("t1_d1", seen[1], S3);
    check("t1_d2", seen[2], S2);
    check("t1_d3", seen[3], S1);

    // leading-zero blanking
    lz = 1'b1;
    run(0, 13'd7, -1, nb, nd);
    grab(0);
    check("t2_d0", seen[0], S7);
    check("t2_d1", seen[1], SB);
    check("t2_d2", seen[2], SB);
    check("t2_d3", seen[3], SB);
    lz = 1'b0;
    grab(0);
    check("t2_nolz_d0", seen[0], S7);
    check("t2_nolz_d1", seen[1], S0);
    check("t2_nolz_d3", seen[3], S0);
    lz = 1'b1;
    run(0, 13'd0, -1, nb, nd);
    grab(0);
    check("t2_zero_d0", seen[0], S0);
    check("t2_zero_d1", seen[1], SB);
    check("t2_zero_d2", seen[2], SB);
    lz = 1'b0;

    // overflow on 3-digit instance
    run(1, 13'd1000, -1, nb, nd);
    check("t3_ovf_done", nd, 1);
    check("t3_ovf", ovf3, 1);
    grab(1);
    check("t3_ovf_d0", seen[0], SD);
    check("t3_ovf_d1", seen[1], SD);
    check("t3_ovf_d2", seen[2], SD);
    run(1, 13'd999, -1, nb, nd);
    check("t3_999_ovf", ovf3, 0);
    grab(1);
    check("t3_999_d0", seen[0], S9);
    check("t3_999_d1", seen[1], S9);
    check("t3_999_d2", seen[2], S9);

    // load while busy is ignored
    run(0, 13'd42, 4, nb, nd);
    check("t4_busy_cycles", nb, 13);
    check("t4_done_pulses", nd, 1);
    grab(0);
    check("t4_d0", seen[0], S2);
    check("t4_d1", seen[1], S4);
    check("t4_d2", seen[2], S0);
    check("t4_d3", seen[3], S0);

    // reset during conversion
    lz = 1'b1;
    @(negedge clk);
    number = 13'd5555;
    load4  = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      load4 = 1'b0;
    end
    check("t5_busy_before", busy4, 1);
    reset_n = 1'b0;
    #1;
    check("t5_rst_busy", busy4, 0);
    check("t5_rst_done", done4, 0);
    check("t5_rst_ovf", ovf4, 0);
    check("t5_rst_anode", anode4, 4'hF);
    check("t5_rst_seg", seg4, SB);
    check("t5_rst_dpn", dp_n4, 1);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("t5_gap_first", anode4, 4'hF);
    @(negedge clk);
    check("t5_lit_digit0", anode4, 4'hE);
    nb = 0;
    nd = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (busy4) nb++;
      if (done4) nd++;
    end
    check("t5_no_busy", nb, 0);
    check("t5_no_done", nd, 0);
    grab(0);
    check("t5_d0", seen[0], S0);
    check("t5_d1", seen[1], SB);
    lz = 1'b0;

    // scan order, gap and decimal point
    dp4   = 4'b0100;
    found = 1'b0;
    prev  = anode4;
    for (int c = 0; c < 60 && !found; c++) begin
      @(negedge clk);
      if (prev == 4'hF && anode4 == 4'hE) found = 1'b1;
      prev = anode4;
    end
    check("t6_sync", found, 1);
    for (int s = 0; s < 5; s++) begin
      lit    = 0;
      gapc   = 0;
      dpl    = 0;
      exp_an = ~(4'b0001 << (s % 4));
      for (int c = 0; c < 10; c++) begin
        if (s != 0 || c != 0) @(negedge clk);
        if (c < 8) begin
          if (anode4 == exp_an) lit++;
          if (!dp_n4) dpl++;
        end else begin
          if (anode4 == 4'hF && seg4 == SB && dp_n4) gapc++;
        end
      end
      check($sformatf("t6_lit_s%0d", s), lit, 8);
      check($sformatf("t6_gap_s%0d", s), gapc, 2);
      check($sformatf("t6_dp_s%0d", s), dpl, (s % 4 == 2) ? 8 : 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_display_scan.md
# bcd_display_scan

Parametrised multi-digit decimal display driver that succeeds the fixed 4-digit BCD/7-segment path. It converts a BIN_W-bit binary value to BCD with a sequential double-dabble engine, one bit per clock, behind a load/busy/done handshake. It latches the result atomically into a display register and time-multiplexes DIGITS common-anode 7-segment digits. It adds leading-zero blanking, per-digit decimal points, overflow indication and anti-ghosting blanking between digit switches. It sits between the ALU result bus and the board display pins.

## Interface

Parameters:
- DIGITS, 4: number of displayed digits, 1..8.
- BIN_W, 13: width of the binary input, 1..27.
- SCAN_DIV, 100000: clk cycles per digit slot. Must be greater than BLANK_CYC.
- BLANK_CYC, 16: clk cycles per slot with all anodes off (ghost suppression). Must be at least 1.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- number  in  BIN_W  binary value, sampled on accepted load.
- load  in  1  start-conversion request.
- dp  in  DIGITS  decimal point enables, bit i = digit i; sampled continuously.
- lz_blank  in  1  1 = blank leading zeros; sampled continuously.
- busy  out  1  conversion in progress.
- done  out  1  one-cycle pulse; new value is visible in the display register.
- overflow  out  1  last converted value was ≥ 10^DIGITS.
- anode  out  DIGITS  active-low one-hot digit enable; digit 0 is the ones digit.
- seg  out  7  active-low segments, seg[6]=a … seg[0]=g.
- dp_n  out  1  active-low decimal point.

## Operation

Converter FSM has two states, IDLE and SHIFT.

**IDLE**
- load=1 at a clk edge captures number into the shift register and clears the BCD field.
- At the same edge, sets ovf_pending = (number ≥ 10^DIGITS).
- Transition to SHIFT with the iteration count at 0.

**SHIFT**
- Each cycle: every 4-bit BCD nibble ≥ 5 gets +3 added, then the whole register shifts left 1.
- After BIN_W iterations, load the BCD field into the display register, set overflow = ovf_pending, pulse done, and return to IDLE.
- load while in SHIFT is ignored. No queueing.
- The BCD field is DIGITS×4 bits. Higher-order BCD carries are discarded; overflow covers that case.

**Display register and output decode**
- The display register changes only on the done edge; a partial conversion is never shown.
- Decode: values 0–9 use the standard active-low patterns (0 = 0000001, 1 = 1001111, … 9 = 0000100).
- Non-BCD nibble decodes to 1111111.
- overflow=1: every digit shows a dash, 1111110. lz_blank is ignored and dp still applies.
- Leading-zero blanking (lz_blank=1): every digit above the most-significant nonzero digit shows 1111111. Digit 0 is never blanked, so value 0 shows "0".
- dp_n = ~dp[idx] while a digit is lit, 1 during the gap.

**Scan**
- A divider counts 0..SCAN_DIV-1 and wraps.
- idx advances 0→1→…→DIGITS-1→0 on divider wrap.
- During divider counts 0..BLANK_CYC-1: anode = all 1s, seg = 1111111.
- Otherwise anode[idx]=0 and all other anode bits = 1.

## Timing

Reset values (reset_n low, takes effect asynchronously):
- busy=0, done=0, overflow=0.
- anode = all 1s, seg = 1111111, dp_n = 1.
- Display register = 0, idx = 0, divider = 0, FSM = IDLE.

Reset behaviour:
- Reset asserted mid-conversion aborts it. No done pulse follows.
- After reset release, the first BLANK_CYC cycles are the gap, then digit 0 lights.

Handshake and latency:
- load accepted at edge k: busy=1 in cycles k+1..k+BIN_W.
- At edge k+BIN_W: busy falls, done=1 for exactly one cycle, and the new display value is visible.
- load high during the done cycle is accepted, since the FSM is already IDLE. Back-to-back throughput is one conversion per BIN_W+1 cycles.

Output registration and scan timing:
- All outputs are registered, with no combinational path from inputs to outputs.
- Each digit is lit for SCAN_DIV-BLANK_CYC cycles per slot.
- Frame period is DIGITS×SCAN_DIV cycles.

## Test plan

Benches run with SCAN_DIV=10 and BLANK_CYC=2.

1. **Basic conversion, DIGITS=4, BIN_W=13.** Load 1234 → busy high 13 cycles, then done one cycle. Slot 0 shows seg 1001100 on anode 1110; slots 1..3 show 3, 2, 1.
2. **Leading-zero blanking.** Load 7 with lz_blank=1 → digit 0 = 0001111, digits 1–3 = 1111111. Toggle lz_blank=0 → digits 1–3 = 0000001, with no reconversion needed. Load 0 with lz_blank=1 → digit 0 = 0000001.
3. **Overflow, DIGITS=3, BIN_W=13.** Load 1000 → overflow=1, all digits 1111110. Then load 999 → overflow=0, display 9 9 9.
4. **Load while busy.** Load 42, then load=1 with number=99 in busy cycle 5 → exactly one done pulse, display 0042, busy not extended.
5. **Reset mid-conversion.** reset_n low during busy cycle 6 of a load of 5555 → all outputs at reset values in the same cycle. After release: busy stays 0, no done pulse, digit 0 shows 0000001 with lz_blank=1.
6. **Scan order and gap.** Free run → each anode is low for 8 cycles, followed by 2 all-high cycles. Order is anode[0], [1], [2], [3], [0]. dp=0100 drives dp_n=0 only while anode[2]=0.
